// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial adder datapath
//
// Purpose: FSM state type for the SIPO frame collector and the mapping from
//          frame position to destination bit index.
// Contents:
//   sipo_state_t  IDLE / SHIFT
//   bitpos()      frame position p -> word bit index for the chosen bit order

package serial_pkg;

  typedef enum logic {IDLE, SHIFT} sipo_state_t;

  // LSB-first frames fill the word upward from bit 0; MSB-first frames fill
  // it downward from bit width-1.
  function automatic int unsigned bitpos(input int unsigned p,
                                         input int unsigned width,
                                         input bit          lsb_first);
    return lsb_first ? p : (width - 1 - p);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// rtl/sipo_out_buf.sv - holding buffer with valid/ready handshake and overrun flag
//
// Purpose: holds one assembled frame until the consumer takes it, decides
//          whether a freshly completed frame loads or is dropped.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load_req         a frame completes this cycle
//   frame_word       assembled frame {carry, data}
//   clr_ovr          clears the sticky overrun flag
//   out_ready        consumer accepts sum_out when out_valid=1
//   sum_out          held frame
//   out_valid        sum_out holds an unconsumed frame
//   overrun          sticky: a completed frame was dropped

module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  input  logic [WIDTH:0]   frame_word,
  input  logic             clr_ovr,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum_out,
  output logic             out_valid,
  output logic             overrun
);

  logic accept;
  logic load;
  logic drop;

  // A buffer being drained this cycle counts as free, so a frame completing
  // on the same edge as the accept loads without a bubble.
  always_comb begin
    accept = out_valid && out_ready;
    load   = load_req && (!out_valid || accept);
    drop   = load_req && !load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        sum_out <= frame_word;
      end

      if (load) begin
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      // A new drop outranks a clear arriving in the same cycle.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_frame_deserializer.sv
// rtl/sipo_frame_deserializer.sv - serial-in/parallel-out frame collector for the serial adder
//
// Purpose: shifts WIDTH serial sum bits plus the final carry into a
//          (WIDTH+1)-bit word and hands it to a valid/ready holding buffer.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   serial_in, en    serial data bit and its qualifier
//   start            with en=1, marks serial_in as bit 0 of a new frame
//   carry_in         adder carry, sampled with the last bit of a frame
//   clr_ovr          clears the overrun flag
//   sum_out          held result: [WIDTH] carry, [WIDTH-1:0] data
//   out_valid        sum_out holds an unconsumed frame
//   out_ready        consumer accepts sum_out
//   overrun          sticky: a completed frame was dropped
//   busy             frame in progress

module sipo_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             en,
  input  logic             start,
  input  logic             carry_in,
  input  logic             clr_ovr,
  output logic [WIDTH:0]   sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  import serial_pkg::*;

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_POS = CW'(WIDTH - 1);

  sipo_state_t        state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   shreg;

  logic [CW-1:0]      wr_pos;
  logic [CW-1:0]      wr_idx;
  logic [WIDTH-1:0]   frame_data;
  logic               frame_done;

  // frame_data is the shift register with the current bit already merged in;
  // it is both the next shift register value and, on the last bit, the
  // completed data handed to the buffer in the same cycle.
  always_comb begin
    wr_pos     = (start || state == IDLE) ? '0 : cnt;
    wr_idx     = CW'(bitpos(int'(wr_pos), WIDTH, LSB_FIRST));
    frame_data = shreg;
    frame_data[wr_idx] = serial_in;
    frame_done = en && !start && (state == SHIFT) && (cnt == LAST_POS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (en) begin
      if (start) begin
        // Start in SHIFT aborts the partial frame silently.
        shreg <= frame_data;
        cnt   <= CW'(1);
        state <= SHIFT;
      end else if (state == SHIFT) begin
        shreg <= frame_data;
        if (cnt == LAST_POS) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == SHIFT);

  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load_req   (frame_done),
    .frame_word ({carry_in, frame_data}),
    .clr_ovr    (clr_ovr),
    .out_ready  (out_ready),
    .sum_out    (sum_out),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// tb/tb_sipo_frame_deserializer.sv - directed vector bench for sipo_frame_deserializer

module tb_sipo_frame_deserializer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       en;
  logic       start;
  logic       carry_in;
  logic       clr_ovr;
  logic       out_ready;
  logic [8:0] sum_l, sum_m;
  logic       valid_l, valid_m;
  logic       ovr_l, ovr_m;
  logic       busy_l, busy_m;

  int checks   = 0;
  int failures = 0;

  sipo_frame_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .en(en), .start(start),
    .carry_in(carry_in), .clr_ovr(clr_ovr), .sum_out(sum_l), .out_valid(valid_l),
    .out_ready(out_ready), .overrun(ovr_l), .busy(busy_l)
  );

  sipo_frame_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .en(en), .start(start),
    .carry_in(carry_in), .clr_ovr(clr_ovr), .sum_out(sum_m), .out_valid(valid_m),
    .out_ready(out_ready), .overrun(ovr_m), .busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, start, sin, carry, rdy, clr;
    logic [8:0] el, em;
    logic       ev, eo, eb;
  } vec_t;

  vec_t vq[$];

  function automatic void row(input logic e, input logic s, input logic b, input logic c,
                              input logic r, input logic k,
                              input logic [8:0] el, input logic [8:0] em,
                              input logic ev, input logic eo, input logic eb);
    vec_t v;
    v.en = e; v.start = s; v.sin = b; v.carry = c; v.rdy = r; v.clr = k;
    v.el = el; v.em = em; v.ev = ev; v.eo = eo; v.eb = eb;
    vq.push_back(v);
  endfunction

  // seq[7] is sent first. Rows 0..6 expect the mid values with busy=1,
  // the last row expects the final values with busy=0.
  function automatic void frame(input logic [7:0] seq, input logic c,
                                input logic rm, input logic rl, input logic kl,
                                input logic [8:0] ml, input logic [8:0] mm,
                                input logic mv, input logic mo,
                                input logic [8:0] fl, input logic [8:0] fm,
                                input logic fv, input logic fo);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) row(1'b1, i == 0, seq[7-i], 1'b0, rm, 1'b0, ml, mm, mv, mo, 1'b1);
      else       row(1'b1, 1'b0,   seq[0],   c,    rl, kl,   fl, fm, fv, fo, 1'b0);
    end
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic b, input logic c,
                       input logic r, input logic k);
    en = e; start = s; serial_in = b; carry_in = c; out_ready = r; clr_ovr = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [8:0] el, input logic [8:0] em,
                         input logic ev, input logic eo, input logic eb);
    chk({tag, ".sum_l"},   sum_l,           el);
    chk({tag, ".sum_m"},   sum_m,           em);
    chk({tag, ".valid_l"}, {8'd0, valid_l}, {8'd0, ev});
    chk({tag, ".valid_m"}, {8'd0, valid_m}, {8'd0, ev});
    chk({tag, ".ovr"},     {8'd0, ovr_l},   {8'd0, eo});
    chk({tag, ".busy"},    {8'd0, busy_l},  {8'd0, eb});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("reset", 9'h000, 9'h000, 0, 0, 0);
    rst = 1'b0;

    // Frame 11101011 carry 1; ready high before valid is ignored.
    frame(8'b11101011, 1, 1, 1, 0, 9'h000, 9'h000, 0, 0, 9'h1D7, 9'h1EB, 1, 0);
    row(0, 0, 0, 0, 1, 0, 9'h1D7, 9'h1EB, 0, 0, 0);
    // Same bits carry 0.
    frame(8'b11101011, 0, 1, 1, 0, 9'h1D7, 9'h1EB, 0, 0, 9'h0D7, 9'h0EB, 1, 0);
    row(0, 0, 0, 0, 1, 0, 9'h0D7, 9'h0EB, 0, 0, 0);
    // Gapped frame 1,0,0,0,0,0,0,1; en=0 rows carry junk start/serial_in.
    row(1, 1, 1, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(0, 1, 1, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(0, 0, 1, 1, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(0, 0, 0, 0, 0, 0, 9'h0D7, 9'h0EB, 0, 0, 1);
    row(1, 0, 1, 0, 0, 0, 9'h081, 9'h081, 1, 0, 0);
    // Back-to-back frame with ready low: dropped, overrun set.
    frame(8'b01010101, 1, 0, 0, 0, 9'h081, 9'h081, 1, 0, 9'h081, 9'h081, 1, 1);
    // Another drop with clr_ovr on the same edge: set wins.
    frame(8'b00001111, 0, 0, 0, 1, 9'h081, 9'h081, 1, 1, 9'h081, 9'h081, 1, 1);
    row(0, 0, 0, 0, 0, 1, 9'h081, 9'h081, 1, 0, 0);
    row(0, 0, 0, 0, 1, 0, 9'h081, 9'h081, 0, 0, 0);
    // Frame E held, then frame D completes on the accepting edge.
    frame(8'b10000000, 1, 0, 0, 0, 9'h081, 9'h081, 0, 0, 9'h101, 9'h180, 1, 0);
    frame(8'b11001010, 0, 0, 1, 0, 9'h101, 9'h180, 1, 0, 9'h053, 9'h0CA, 1, 0);
    row(0, 0, 0, 0, 0, 0, 9'h053, 9'h0CA, 1, 0, 0);
    row(0, 0, 0, 0, 1, 0, 9'h053, 9'h0CA, 0, 0, 0);
    // Abort: four partial bits, then start again with 0xFF.
    row(1, 1, 1, 0, 0, 0, 9'h053, 9'h0CA, 0, 0, 1);
    row(1, 0, 0, 1, 0, 0, 9'h053, 9'h0CA, 0, 0, 1);
    row(1, 0, 1, 1, 0, 0, 9'h053, 9'h0CA, 0, 0, 1);
    row(1, 0, 0, 1, 0, 0, 9'h053, 9'h0CA, 0, 0, 1);
    frame(8'hFF, 0, 0, 0, 0, 9'h053, 9'h0CA, 0, 0, 9'h0FF, 9'h0FF, 1, 0);
    row(0, 0, 0, 0, 1, 0, 9'h0FF, 9'h0FF, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].start, vq[i].sin, vq[i].carry, vq[i].rdy, vq[i].clr);
      chk_all($sformatf("vec%0d", i), vq[i].el, vq[i].em, vq[i].ev, vq[i].eo, vq[i].eb);
    end

    // Reset mid-frame while a result is held.
    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0] s = 8'b11101011;
      drive(1, i == 0, s[7-i], i == 7, 0, 0);
    end
    chk_all("held", 9'h1D7, 9'h1EB, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, i == 0, 1, 0, 0, 0);
    chk_all("partial", 9'h1D7, 9'h1EB, 1, 0, 1);
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 0);
    rst = 1'b0;
    chk_all("midrst", 9'h000, 9'h000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      automatic logic [7:0] s = 8'b00110101;
      drive(1, i == 0, s[7-i], i == 7, 0, 0);
    end
    chk_all("postrst", 9'h1AC, 9'h135, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk_all("postrst_acc", 9'h1AC, 9'h135, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
